// File: rtl/bcd_down_counter_pkg.sv
// Shared state encoding, BCD constants and load-value sanitising for bcd_down_counter.
package bcd_down_counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;

  // Nibbles A-F are not decimal digits; clamp them to 9.
  function automatic logic [3:0] bcd_sanitise(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One combinational BCD digit of the down-counter: decrement on borrow_in, 0 -> 9 with borrow_out.
import bcd_down_counter_pkg::*;

module bcd_down_digit (
  input  logic [3:0] digit,
  input  logic       borrow_in,
  output logic [3:0] next_digit,
  output logic       borrow_out
);

  assign borrow_out = borrow_in & (digit == BCD_ZERO);

  always_comb begin
    next_digit = digit;
    if (borrow_in) begin
      next_digit = (digit == BCD_ZERO) ? BCD_MAX : digit - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_down_counter.sv
// Multi-digit BCD countdown timer with load, pause and one-cycle terminal-count pulse.
// Build option: BCD_DOWN_COUNTER_AUTO_RELOAD_EN reloads the last loaded value at terminal count.
import bcd_down_counter_pkg::*;

module bcd_down_counter #(
  parameter int unsigned DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  en,
  output logic [4*DIGITS-1:0]   cnt,
  output logic                  zero,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned W = 4 * DIGITS;

  state_t         state_q, state_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic           done_q, done_d;
  logic [W-1:0]   load_bcd;
  logic [W-1:0]   dec_val;
  logic [DIGITS:0] borrow;

  assign borrow[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_down_digit u_digit (
      .digit      (cnt_q[4*g +: 4]),
      .borrow_in  (borrow[g]),
      .next_digit (dec_val[4*g +: 4]),
      .borrow_out (borrow[g+1])
    );
  end

  always_comb begin
    load_bcd = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      load_bcd[4*i +: 4] = bcd_sanitise(load_val[4*i +: 4]);
    end
  end

`ifdef BCD_DOWN_COUNTER_AUTO_RELOAD_EN
  logic [W-1:0] reload_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reload_q <= '0;
    end else if (load) begin
      reload_q <= load_bcd;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (load) begin
      cnt_d   = load_bcd;
      state_d = (load_bcd == '0) ? IDLE : RUN;
    end else if (state_q == RUN && en) begin
      if (cnt_q == W'(1)) begin
        done_d = 1'b1;
`ifdef BCD_DOWN_COUNTER_AUTO_RELOAD_EN
        cnt_d   = reload_q;
`else
        cnt_d   = '0;
        state_d = DONE;
`endif
      end else if (!borrow[DIGITS]) begin
        // A final borrow means cnt was all zeros; hold rather than wrap to all-9s.
        cnt_d = dec_val;
      end
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);
  assign busy = (state_q == RUN);
  assign done = done_q;

endmodule

// File: tb/tb_bcd_down_counter.sv
// Directed self-checking bench for bcd_down_counter (DIGITS=2).
module tb_bcd_down_counter;

  logic       clk;
  logic       rst;
  logic       load;
  logic [7:0] load_val;
  logic       en;
  logic [7:0] cnt;
  logic       zero;
  logic       busy;
  logic       done;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  bcd_down_counter #(.DIGITS(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .en       (en),
    .cnt      (cnt),
    .zero     (zero),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] e_cnt, input logic e_busy,
                           input logic e_done);
    check({tag, ".cnt"},  32'(cnt),  32'(e_cnt));
    check({tag, ".zero"}, 32'(zero), 32'(e_cnt == 8'h00));
    check({tag, ".busy"}, 32'(busy), 32'(e_busy));
    check({tag, ".done"}, 32'(done), 32'(e_done));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; load = 1'b0; load_val = 8'h00; en = 1'b0;
    #1;
    check_all("reset", 8'h00, 1'b0, 1'b0);
    step(); step();
    rst = 1'b1;
    step();
    check_all("idle_after_reset", 8'h00, 1'b0, 1'b0);

    // Full countdown from 25
    load = 1'b1; load_val = 8'h25; en = 1'b1;
    step();
    load = 1'b0;
    check_all("load25", 8'h25, 1'b1, 1'b0);
    for (int v = 24; v >= 0; v--) begin
      step();
      check_all($sformatf("count%0d", v), to_bcd(v), v != 0, v == 0);
    end
    step();
    check_all("done_drop", 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step();
      check_all($sformatf("done_hold%0d", k), 8'h00, 1'b0, 1'b0);
    end

    // Borrow across digits and sanitising
    load = 1'b1; load_val = 8'h10;
    step();
    load = 1'b0;
    check_all("load10", 8'h10, 1'b1, 1'b0);
    step();
    check_all("borrow09", 8'h09, 1'b1, 1'b0);
    step();
    check_all("dec08", 8'h08, 1'b1, 1'b0);
    load = 1'b1; load_val = 8'h3C;
    step();
    load = 1'b0; en = 1'b0;
    check_all("sanitise3C", 8'h39, 1'b1, 1'b0);
    load = 1'b1; load_val = 8'hFA; en = 1'b0;
    step();
    load = 1'b0;
    check_all("sanitiseFA", 8'h99, 1'b1, 1'b0);

    // Pause
    load = 1'b1; load_val = 8'h05;
    step();
    load = 1'b0;
    check_all("load05", 8'h05, 1'b1, 1'b0);
    en = 1'b1; step(); check_all("pause_a", 8'h04, 1'b1, 1'b0);
    en = 1'b0; step(); check_all("pause_b", 8'h04, 1'b1, 1'b0);
    en = 1'b0; step(); check_all("pause_c", 8'h04, 1'b1, 1'b0);
    en = 1'b1; step(); check_all("pause_d", 8'h03, 1'b1, 1'b0);

    // Asynchronous reset mid-cycle
    #2 rst = 1'b0;
    #1;
    check_all("async_reset", 8'h00, 1'b0, 1'b0);
    step();
    rst = 1'b1;
    step();
    check_all("post_reset_idle", 8'h00, 1'b0, 1'b0);

    // Load beats enable; load of zero
    load = 1'b1; load_val = 8'h07; en = 1'b1;
    step();
    check_all("load_over_en", 8'h07, 1'b1, 1'b0);
    load_val = 8'h00;
    step();
    load = 1'b0;
    check_all("load00", 8'h00, 1'b0, 1'b0);
    step();
    check_all("idle_ignores_en", 8'h00, 1'b0, 1'b0);

    // Terminal count from 01
    load = 1'b1; load_val = 8'h01;
    step();
    load = 1'b0;
    check_all("load01", 8'h01, 1'b1, 1'b0);
    step();
`ifdef BCD_DOWN_COUNTER_AUTO_RELOAD_EN
    check_all("tc01", 8'h01, 1'b1, 1'b1);
    step();
    check_all("tc01_again", 8'h01, 1'b1, 1'b1);
`else
    check_all("tc01", 8'h00, 1'b0, 1'b1);
    step();
    check_all("tc01_after", 8'h00, 1'b0, 1'b0);
`endif

`ifdef BCD_DOWN_COUNTER_AUTO_RELOAD_EN
    begin
      logic [7:0] seq [9] = '{8'h02, 8'h01, 8'h03, 8'h02, 8'h01, 8'h03, 8'h02, 8'h01, 8'h03};
      load = 1'b1; load_val = 8'h03;
      step();
      load = 1'b0;
      check_all("ar_load03", 8'h03, 1'b1, 1'b0);
      for (int k = 0; k < 9; k++) begin
        step();
        check_all($sformatf("ar%0d", k), seq[k], 1'b1, (k % 3) == 2);
      end
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
